// File: rtl/uart_pkg.sv
// Shared definitions for the burst UART transmitter: FSM encoding, parity modes
// and the parity helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_PAR   = 3'd3,
    ST_STOP  = 3'd4
  } state_e;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  function automatic logic parity8(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period divider: bit_end is high in the last cycle of every BAUD_DIV-cycle
// bit; clear restarts the period so a new bit begins at the next edge.
module uart_baud_tick #(
  parameter int unsigned BAUD_DIV = 217
) (
  input  logic Clock,
  input  logic Reset,
  input  logic clear,
  output logic bit_end
);

  localparam int unsigned CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          bit_end_q, bit_end_d;

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || (cnt_q == LAST)) cnt_d = '0;
    bit_end_d = (cnt_d == LAST);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      cnt_q     <= '0;
      bit_end_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bit_end_q <= bit_end_d;
    end
  end

  assign bit_end = bit_end_q;

endmodule

// File: rtl/uart_burst_tx.sv
// Multi-byte UART burst transmitter: latches a byte buffer and count on trig_in
// and sends the bytes back-to-back as start/8 data/optional parity/stop frames.
module uart_burst_tx
  import uart_pkg::*;
#(
  parameter int unsigned MAX_BYTES  = 8,
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned BAUD_DIV   = 217,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned BYTE_ORDER = 0
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic [8*MAX_BYTES-1:0] buffer,
  input  logic [CNT_W-1:0]       num,
  input  logic                   trig_in,
  input  logic                   abort,
  output logic                   idle,
  output logic                   done,
  output logic                   TX
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BYTES);
  localparam bit   PAR_EN    = (PARITY == PAR_EVEN) || (PARITY == PAR_ODD);
  localparam bit   PAR_INV   = (PARITY == PAR_ODD) && (PARITY != PAR_NONE);
  localparam logic STOP_LAST = 1'(STOP_BITS - 1);

  state_e                 state_q, state_d;
  logic [8*MAX_BYTES-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]       idx_q, idx_d, rem_q, rem_d, num_eff;
  logic [2:0]             bit_q, bit_d;
  logic                   stop_q, stop_d;
  logic [7:0]             shift_q, shift_d, cur_byte;
  logic                   par_q, par_d;
  logic                   tx_q, tx_d, idle_q, idle_d, done_q, done_d;
  logic                   bit_end, start, abort_busy, clear;

  assign num_eff    = (num > MAX_CNT) ? MAX_CNT : num;
  assign start      = (state_q == ST_IDLE) && trig_in && !abort;
  assign abort_busy = abort && (state_q != ST_IDLE);
  assign clear      = start || abort_busy;

  uart_baud_tick #(
    .BAUD_DIV(BAUD_DIV)
  ) u_baud (
    .Clock  (Clock),
    .Reset  (Reset),
    .clear  (clear),
    .bit_end(bit_end)
  );

  // Byte currently addressed in the latched buffer.
  always_comb begin
    cur_byte = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (idx_q == CNT_W'(i)) cur_byte = buf_q[8*i +: 8];
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort_busy) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start && (num_eff != '0)) state_d = ST_START;
        ST_START: if (bit_end) state_d = ST_DATA;
        ST_DATA:  if (bit_end && (bit_q == 3'd7)) state_d = PAR_EN ? ST_PAR : ST_STOP;
        ST_PAR:   if (bit_end) state_d = ST_STOP;
        ST_STOP:  if (bit_end && (stop_q == STOP_LAST))
                    state_d = (rem_q == '0) ? ST_IDLE : ST_START;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    buf_d   = buf_q;
    idx_d   = idx_q;
    rem_d   = rem_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    done_d  = 1'b0;

    if (start) begin
      buf_d  = buffer;
      rem_d  = num_eff - CNT_W'(1);
      idx_d  = (BYTE_ORDER != 0) ? num_eff - CNT_W'(1) : '0;
      done_d = (num_eff == '0);
    end
    if ((state_q == ST_START) && (state_d == ST_DATA)) begin
      shift_d = cur_byte;
      par_d   = parity8(cur_byte) ^ PAR_INV;
      bit_d   = '0;
    end
    if ((state_q == ST_DATA) && bit_end && (state_d == ST_DATA)) begin
      shift_d = shift_q >> 1;
      bit_d   = bit_q + 3'd1;
    end
    if ((state_q != ST_STOP) && (state_d == ST_STOP)) stop_d = 1'b0;
    if ((state_q == ST_STOP) && bit_end && (state_d == ST_STOP)) stop_d = 1'b1;
    if ((state_q == ST_STOP) && (state_d == ST_START)) begin
      rem_d = rem_q - CNT_W'(1);
      idx_d = (BYTE_ORDER != 0) ? idx_q - CNT_W'(1) : idx_q + CNT_W'(1);
    end
    if ((state_q == ST_STOP) && !abort && (state_d == ST_IDLE)) done_d = 1'b1;

    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      ST_PAR:   tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    idle_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      buf_q   <= '0;
      idx_q   <= '0;
      rem_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      idx_q   <= idx_d;
      rem_q   <= rem_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      idle_q  <= idle_d;
      done_q  <= done_d;
    end
  end

  assign TX   = tx_q;
  assign idle = idle_q;
  assign done = done_q;

endmodule

// File: tb/tb_uart_burst_tx.sv
// Directed bench for uart_burst_tx: four instances covering byte order, parity
// and stop-bit variants, driven from a vector table plus corner-case sequences.
module tb_uart_burst_tx;

  localparam int BD = 4;
  localparam logic [63:0] BUF_A = 64'h55aaff001248137f;
  localparam logic [63:0] BUF_B = 64'h000000000000a503;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] buffer;
  logic [3:0]  num;
  logic [3:0]  trig;
  logic        abort;
  logic [3:0]  idle, done, tx;

  int par_cfg   [4] = '{0, 0, 1, 2};
  int stop_cfg  [4] = '{1, 1, 1, 2};
  int order_cfg [4] = '{0, 1, 0, 0};

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    uart_burst_tx #(
      .MAX_BYTES (8),
      .CNT_W     (4),
      .BAUD_DIV  (BD),
      .PARITY    ((g == 2) ? 1 : (g == 3) ? 2 : 0),
      .STOP_BITS ((g == 3) ? 2 : 1),
      .BYTE_ORDER((g == 1) ? 1 : 0)
    ) u_dut (
      .Clock  (clk),
      .Reset  (rst_n),
      .buffer (buffer),
      .num    (num),
      .trig_in(trig[g]),
      .abort  (abort),
      .idle   (idle[g]),
      .done   (done[g]),
      .TX     (tx[g])
    );
  end

  typedef struct {
    int          dut;
    logic [63:0] buf_v;
    logic [3:0]  num;
    int          exp_len;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    logic        retrig;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic int frame_bits(input int d);
    return 9 + ((par_cfg[d] != 0) ? 1 : 0) + stop_cfg[d];
  endfunction

  // Expected TX level j cycles after the triggering edge.
  function automatic logic model_tx(input int d, input logic [63:0] b, input logic [3:0] n, input int j);
    int neff, fb, bitn, slot, pos, idx;
    logic [7:0] byt;
    neff = (n > 4'd8) ? 8 : int'(n);
    fb   = frame_bits(d);
    bitn = j / BD;
    if (bitn >= neff * fb) return 1'b1;
    slot = bitn / fb;
    pos  = bitn % fb;
    idx  = (order_cfg[d] != 0) ? neff - 1 - slot : slot;
    byt  = b[8*idx +: 8];
    if (pos == 0) return 1'b0;
    if (pos <= 8) return byt[pos-1];
    if ((par_cfg[d] != 0) && (pos == 9)) return (^byt) ^ (par_cfg[d] == 2);
    return 1'b1;
  endfunction

  // Call right after a falling edge: triggers now and watches the whole burst.
  task automatic run_vec(input int vi, input vec_t v);
    int d, busy, dones, done_at, tx_bad, last_start, rel;
    logic [7:0] fbyte, lbyte;
    d = v.dut; busy = 0; dones = 0; done_at = -1; tx_bad = 0;
    fbyte = '0; lbyte = '0;
    last_start = v.exp_len - frame_bits(d) * BD;
    buffer = v.buf_v; num = v.num; trig[d] = 1'b1;
    @(negedge clk);
    trig = '0; buffer = ~v.buf_v; num = ~v.num;
    for (int j = 0; j < v.exp_len + 8; j++) begin
      if (!idle[d]) busy++;
      if (done[d]) begin
        dones++;
        if (done_at < 0) done_at = j;
      end
      if (tx[d] !== model_tx(d, v.buf_v, v.num, j)) tx_bad++;
      if ((j % BD) == 2 && (j / BD) >= 1 && (j / BD) <= 8) fbyte[j/BD-1] = tx[d];
      rel = j - last_start;
      if (rel >= 0 && (rel % BD) == 2 && (rel / BD) >= 1 && (rel / BD) <= 8) lbyte[rel/BD-1] = tx[d];
      trig[d] = v.retrig && (j == 20);
      @(negedge clk);
    end
    trig = '0;
    chk($sformatf("v%0d busy_cycles", vi), 64'(busy), 64'(v.exp_len));
    chk($sformatf("v%0d done_count", vi), 64'(dones), 64'd1);
    chk($sformatf("v%0d done_cycle", vi), 64'(done_at), 64'(v.exp_len));
    chk($sformatf("v%0d tx_bad_cycles", vi), 64'(tx_bad), 64'd0);
    if (v.exp_len > 0) begin
      chk($sformatf("v%0d first_byte", vi), 64'(fbyte), 64'(v.exp_first));
      chk($sformatf("v%0d last_byte", vi), 64'(lbyte), 64'(v.exp_last));
    end
  endtask

  initial begin
    int dn;
    rst_n = 1'b0; buffer = '0; num = '0; trig = '0; abort = 1'b0;

    vecs[0]  = '{0, BUF_A, 4'd8,  320, 8'h7f, 8'h55, 1'b0};
    vecs[1]  = '{1, BUF_A, 4'd8,  320, 8'h55, 8'h7f, 1'b0};
    vecs[2]  = '{2, BUF_A, 4'd1,  44,  8'h7f, 8'h7f, 1'b0};
    vecs[3]  = '{3, BUF_A, 4'd1,  48,  8'h7f, 8'h7f, 1'b0};
    vecs[4]  = '{0, BUF_A, 4'd0,  0,   8'h00, 8'h00, 1'b0};
    vecs[5]  = '{0, BUF_A, 4'd12, 320, 8'h7f, 8'h55, 1'b0};
    vecs[6]  = '{0, BUF_A, 4'd8,  320, 8'h7f, 8'h55, 1'b1};
    vecs[7]  = '{0, BUF_A, 4'd3,  120, 8'h7f, 8'h48, 1'b0};
    vecs[8]  = '{2, BUF_B, 4'd2,  88,  8'h03, 8'ha5, 1'b0};
    vecs[9]  = '{1, BUF_A, 4'd3,  120, 8'h48, 8'h7f, 1'b0};
    vecs[10] = '{3, BUF_B, 4'd2,  96,  8'h03, 8'ha5, 1'b1};

    repeat (3) @(negedge clk);
    chk("reset_idle", 64'(idle), 64'hf);
    chk("reset_done", 64'(done), 64'h0);
    chk("reset_tx", 64'(tx), 64'hf);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      run_vec(i, vecs[i]);
    end

    // abort and trig together while idle: no burst starts
    buffer = BUF_A; num = 4'd8; trig[0] = 1'b1; abort = 1'b1;
    @(negedge clk);
    trig = '0; abort = 1'b0;
    chk("abort_trig_idle", 64'({idle[0], done[0], tx[0]}), 64'b101);

    // abort mid-burst, then a fresh burst on the next cycle
    trig[0] = 1'b1;
    @(negedge clk);
    trig = '0;
    repeat (50) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 64'({idle[0], done[0], tx[0]}), 64'b101);
    run_vec(11, vecs[0]);

    // reset while a data bit is low
    buffer = BUF_A; num = 4'd8; trig[0] = 1'b1;
    @(negedge clk);
    trig = '0;
    repeat (54) @(negedge clk);
    chk("pre_reset_tx", 64'(tx[0]), 64'd0);
    chk("pre_reset_idle", 64'(idle[0]), 64'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("mid_reset", 64'({idle[0], done[0], tx[0]}), 64'b101);
    dn = 0;
    repeat (12) begin
      @(negedge clk);
      if (done[0] || !idle[0] || !tx[0]) dn++;
    end
    chk("post_reset_quiet", 64'(dn), 64'd0);
    run_vec(12, vecs[7]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
